// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver: pin synchronisation and glitch filtering,
// frame validation (parity, stop bit, timeout), and folding of E0/F0/E1
// prefix bytes into a single 11-bit key event word for the matrix block.
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_stb,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Index 0 is the PS/2 clock, index 1 is the PS/2 data line.
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          filt_clk_d;
    logic          fall;
    logic          bit_in;

    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;

    logic       ext_flag;
    logic       brk_flag;
    logic [2:0] skip_cnt;

    assign fall   = filt_clk_d & ~filt[0];
    assign bit_in = filt[1];

    // Two-stage synchroniser for both pins; idle bus level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {ps2_data_i, ps2_clk_i};
            sync2 <= sync1;
        end
    end

    // Glitch filter: the level only follows after FILTER_LEN matching samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt       <= '1;
            fcnt[0]    <= '0;
            fcnt[1]    <= '0;
            filt_clk_d <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
            filt_clk_d <= filt[0];
        end
    end

    // Frame FSM with inter-edge timeout; a falling edge beats a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            rx_byte     <= '0;
            rx_byte_stb <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_byte_stb <= 1'b0;
            frame_err   <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= bit_in;
                        state   <= ST_STOP;
                    end
                    default: begin
                        if (bit_in && ((^shift) ^ par_bit)) begin
                            rx_byte     <= shift;
                            rx_byte_stb <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Byte decoder: fold prefixes, skip the Pause tail, emit one-cycle events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            skip_cnt <= '0;
            ps2_key  <= '0;
        end else begin
            ps2_key[10] <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                skip_cnt <= '0;
            end else if (rx_byte_stb) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 1'b1;
                    if (skip_cnt == 3'd1) begin
                        ps2_key <= {1'b1, 1'b0, 1'b1, 8'h77};
                    end
                end else if (rx_byte == 8'hE1) begin
                    skip_cnt <= 3'd7;
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end else if (rx_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (!ext_flag && !brk_flag &&
                             ((rx_byte == 8'hAA) || (rx_byte == 8'hFA) ||
                              (rx_byte == 8'hEE) || (rx_byte == 8'hFE) ||
                              (rx_byte == 8'h00) || (rx_byte == 8'hFF))) begin
                    // Controller status/acknowledge byte: not a key event.
                end else begin
                    ps2_key  <= {1'b1, brk_flag, ext_flag, rx_byte};
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected key events,
// received bytes and frame errors into queues; a monitor pops and compares.
module tb_ps2_key_rx;

    localparam int TO_CYC = 1000;
    localparam int HALF   = 40;
    localparam int GAP    = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_byte_stb;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [10:0] q_key [$];
    logic [7:0]  q_rx  [$];
    int          exp_err = 0;

    // Reference model state: prefix flags and Pause bytes left to swallow.
    bit m_ext = 0;
    bit m_brk = 0;
    int m_skip = 0;

    ps2_key_rx #(
        .FILTER_LEN(8),
        .TIMEOUT_CYCLES(TO_CYC),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk_i(ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_key(ps2_key),
        .rx_byte(rx_byte),
        .rx_byte_stb(rx_byte_stb),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        q_rx.push_back(b);
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) q_key.push_back(11'h577);
        end else if (b == 8'hE1) begin
            m_skip = 7;
            m_ext  = 0;
            m_brk  = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && !m_brk &&
                     (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                      b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
        end else begin
            q_key.push_back({1'b1, m_brk, m_ext, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Drive nbits of a frame onto the pins; data changes while clock is high.
    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = bits[i];
            tick(HALF);
            ps2_clk_i = 1'b0;
            tick(HALF);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        tick(GAP);
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad_par);
        if (bad_par) begin
            exp_err++;
            model_clear();
        end else begin
            model_byte(b);
        end
        drive_frame(b, bad_par, 11);
    endtask

    // Monitor: compare every DUT output pulse against the scoreboard.
    bit          hold_pending = 0;
    logic [10:0] last_key;
    int          cyc = 0;
    int          rx_cyc = -100;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (hold_pending) begin
                check("key_hold", {21'd0, ps2_key}, {21'd0, 1'b0, last_key[9:0]});
                hold_pending = 0;
            end
            if (rx_byte_stb) begin
                rx_cyc = cyc;
                if (q_rx.size() == 0) begin
                    check("rx_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, q_rx.pop_front()});
                end
            end
            if (ps2_key[10]) begin
                check("key_latency", cyc - rx_cyc, 1);
                if (q_key.size() == 0) begin
                    check("key_unexpected", {21'd0, ps2_key}, 32'hFFFF_FFFF);
                end else begin
                    check("ps2_key", {21'd0, ps2_key}, {21'd0, q_key.pop_front()});
                end
                last_key     = ps2_key;
                hold_pending = 1;
            end
            if (frame_err) begin
                check("frame_err_expected", 1, (exp_err > 0) ? 1 : 0);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        int wait_cyc;
        logic [7:0] pause_seq [8];

        // Reset state
        tick(3);
        check("reset_key", {21'd0, ps2_key}, 0);
        check("reset_rx", {24'd0, rx_byte}, 0);
        check("reset_stb", {31'd0, rx_byte_stb}, 0);
        check("reset_err", {31'd0, frame_err}, 0);
        reset = 1'b0;
        tick(20);

        // Plain make code
        xfer(8'h1C, 0);
        check("rx_byte_1C", {24'd0, rx_byte}, 32'h1C);

        // Extended break
        xfer(8'hE0, 0);
        xfer(8'hF0, 0);
        xfer(8'h75, 0);

        // Pause sequence collapses to one event
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) xfer(pause_seq[i], 0);

        // Parity error clears a pending break prefix
        xfer(8'hF0, 0);
        xfer(8'h1C, 1);
        xfer(8'h1C, 0);

        // Timeout mid-frame clears a pending extended prefix
        xfer(8'hE0, 0);
        exp_err++;
        model_clear();
        drive_frame(8'h1C, 0, 5);
        tick(TO_CYC + 300);
        xfer(8'h1C, 0);

        // Short glitches on the idle bus are filtered out
        for (int i = 0; i < 4; i++) begin
            ps2_clk_i = 1'b0;
            tick(3);
            ps2_clk_i = 1'b1;
            ps2_data_i = 1'b0;
            tick(2);
            ps2_data_i = 1'b1;
            tick(20);
        end
        xfer(8'hFA, 0);
        check("rx_byte_FA", {24'd0, rx_byte}, 32'hFA);

        // Reset mid-frame discards partial frame and prefix state
        xfer(8'hE0, 0);
        drive_frame(8'h33, 0, 4);
        reset = 1'b1;
        tick(2);
        check("midreset_key", {21'd0, ps2_key}, 0);
        check("midreset_rx", {24'd0, rx_byte}, 0);
        reset = 1'b0;
        model_clear();
        tick(20);
        xfer(8'h1C, 0);

        // Random traffic with prefixes, status bytes and occasional bad parity
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hAA;
                3: b = 8'hFA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            xfer(b, $urandom_range(0, 7) == 0);
        end

        // Drain with a bounded wait
        wait_cyc = 0;
        while ((q_key.size() != 0 || q_rx.size() != 0 || exp_err != 0) && wait_cyc < 500) begin
            tick(1);
            wait_cyc++;
        end
        tick(5);
        check("key_queue_empty", q_key.size(), 0);
        check("rx_queue_empty", q_rx.size(), 0);
        check("err_pending", exp_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Upstream stage of the keyboard matrix block.
- Receives raw PS/2 device-to-host frames from the keyboard pins and validates them (framing, parity, timeout).
- Folds E0/F0/E1 prefix bytes into a single 11-bit event word `ps2_key` = {strobe, break, extended, scancode}. The matrix block consumes this word directly.
- Sits between the board PS/2 pins and the keyboard/matrix logic in the `clk` domain.

Parameters:
- FILTER_LEN, 8: consecutive identical `clk` samples required before the filtered PS/2 clock/data level changes.
- TIMEOUT_CYCLES, 50000: `clk` cycles allowed between PS/2 clock falling edges inside a frame before the frame is abandoned (2 ms at 25 MHz).
- TO_W, 16: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ps2_clk_i, input, 1: raw PS/2 clock pin (asynchronous to `clk`).
- ps2_data_i, input, 1: raw PS/2 data pin (asynchronous to `clk`).
- ps2_key, output, 11: [10] one-cycle event strobe, [9] break, [8] extended, [7:0] scancode.
- rx_byte, output, 8: last byte that passed parity and stop checks (debug).
- rx_byte_stb, output, 1: one-cycle pulse when `rx_byte` updates.
- frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- **Reset.** All outputs are 0; FSM is IDLE; all prefix flags are clear; filters are preset to 1 (idle bus). Reset asserted mid-frame discards all partial state immediately.
- **Input conditioning.** Each pin passes through a 2-FF synchroniser, then the FILTER_LEN glitch filter. A bit is sampled on a falling edge of the filtered clock (1->0), using the filtered data level at that cycle.
- **Frame FSM.**
  - IDLE: start bit 0 -> DATA, bit count = 0. Start bit 1 is ignored silently.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: valid when the stop bit is 1 and the XOR of the 8 data bits and parity is 1 (odd parity). Either way -> IDLE.
  - Valid frame: byte is presented to the decoder next cycle; `rx_byte_stb` pulses.
  - Invalid frame: `frame_err` pulses and the E0/F0/E1 state is cleared.
- **Timeout.** The counter resets on every filtered falling edge and counts only outside IDLE. Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses `frame_err` and clears all prefix state.
- **Byte decoder** (runs one cycle after a valid byte):
  - E1 skip count nonzero: decrement it. When it reaches 0, emit {1,0,1,8'h77} (Pause as E0-77 make). No break event is ever emitted for Pause.
  - 8'hE1: load skip count = 7; clear E0/F0.
  - 8'hE0: set ext flag; no emit.
  - 8'hF0: set brk flag; no emit.
  - 8'hAA, FA, EE, FE, 00, FF with both flags clear: controller status; no emit.
  - Any other byte: emit {1, brk, ext, byte}; clear both flags.
- **Emission timing.** `ps2_key[10]` is high for exactly one cycle. `ps2_key[9:0]` hold the last event until the next one. Latency is 2 `clk` cycles from the stop-bit falling edge to the strobe.
- **Simultaneous events.** Emission and a new start bit cannot conflict because the decoder finishes within 1 cycle. A timeout and a falling edge in the same cycle: the edge wins and the counter restarts.

Test Plan:
1. Frame 0x1C (parity 0, stop 1) with 40 us bit cells -> 2 cycles after the stop edge `ps2_key` = 11'h41C for one cycle, then 11'h01C. `rx_byte` = 1C.
2. Bytes E0, F0, 75 -> a single event 11'h775 (strobe, brk, ext, 75). No events for the prefixes.
3. Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event, 11'h577, emitted after the final byte.
4. Frame 0x1C with parity bit 1 -> `frame_err` pulses, no `ps2_key` strobe. A following valid 0x1C emits 11'h41C (prefix state cleared).
5. E0, then a frame cut after 4 data bits, idle > TIMEOUT_CYCLES -> `frame_err` pulse, FSM IDLE. A following 0x1C emits 11'h41C with ext = 0.
6. 3-cycle glitch pulses on `ps2_clk_i` while idle, plus byte 0xFA -> no strobe, no `frame_err`. `rx_byte` = FA on the valid frame.
